// File: rtl/xc_sha3_seq_pkg.sv
// Shared types for the SHA3 lane sequencer.
// Op encodings, FSM states, lane extents.
package xc_sha3_seq_pkg;

  localparam int NX_DEF = 5;
  localparam int NY_DEF = 5;
  localparam int CW     = 3;

  typedef enum logic [2:0] {
    OP_XY = 3'd0,
    OP_X1 = 3'd1,
    OP_X2 = 3'd2,
    OP_X4 = 3'd3,
    OP_YX = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  function automatic logic op_legal(
    input logic [2:0] op
  );
    return op <= 3'(OP_YX);
  endfunction

endpackage

// File: rtl/xc_sha3_lane_ctr.sv
// Keccak lane coordinate counter.
// x inner, y outer, both wrap; last flags (NX-1,NY-1).
module xc_sha3_lane_ctr
  import xc_sha3_seq_pkg::*;
#(
  parameter int NX = NX_DEF,
  parameter int NY = NY_DEF
) (
  input  logic          g_clk,
  input  logic          g_reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          last
);

  logic x_end;
  logic y_end;

  assign x_end = (x == CW'(NX - 1));
  assign y_end = (y == CW'(NY - 1));
  assign last  = x_end && y_end;

  // Advance x each enable, carry into y on x wrap.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/xc_sha3_lane_seq.sv
// SHA3 lane-index sequencer: walks 25 lanes, emits address beats.
// XC_SHA3_LANE_SEQ_BASE_EN adds a latched base to each address.
module xc_sha3_lane_seq
  import xc_sha3_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NX     = NX_DEF,
  parameter int NY     = NY_DEF
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [1:0]        shamt,
  input  logic [ADDR_W-1:0] base,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       sha3_rs1,
  output logic [31:0]       sha3_rs2,
  output logic [1:0]        sha3_shamt,
  output logic              sha3_f_xy,
  output logic              sha3_f_x1,
  output logic              sha3_f_x2,
  output logic              sha3_f_x4,
  output logic              sha3_f_yx,
  input  logic [ADDR_W-1:0] sha3_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [2:0]        out_x,
  output logic [2:0]        out_y,
  output logic              out_last
);

  state_e            state_q;
  state_e            state_d;
  logic [2:0]        op_q;
  logic [1:0]        shamt_q;
  logic [CW-1:0]     x;
  logic [CW-1:0]     y;
  logic              c_last;
  logic              start_ok;
  logic              start_bad;
  logic              load;
  logic              acc_last;
  logic              kill;
  logic [ADDR_W-1:0] addr_d;

  assign start_ok  = (state_q == S_IDLE) && start
                  && op_legal(op);
  assign start_bad = (state_q == S_IDLE) && start
                  && !op_legal(op);
  assign kill      = (state_q != S_IDLE) && abort;
  assign load      = (state_q == S_RUN) && !abort
                  && (!out_valid || out_ready);
  assign acc_last  = out_valid && out_ready && out_last;

  xc_sha3_lane_ctr #(
    .NX (NX),
    .NY (NY)
  ) u_ctr (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .clr     (start_ok),
    .en      (load),
    .x       (x),
    .y       (y),
    .last    (c_last)
  );

  assign sha3_rs1   = {{(32-CW){1'b0}}, x};
  assign sha3_rs2   = {{(32-CW){1'b0}}, y};
  assign sha3_shamt = shamt_q;

`ifdef XC_SHA3_LANE_SEQ_BASE_EN
  logic [ADDR_W-1:0] base_q;

  // Base is captured alongside op on a legal start.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset)       base_q <= '0;
    else if (start_ok) base_q <= base;
  end

  assign addr_d = sha3_result + base_q;
`else
  logic unused_base;

  assign unused_base = ^base;
  assign addr_d      = sha3_result;
`endif

  // Command latch for op and shift amount.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      op_q    <= '0;
      shamt_q <= '0;
    end else if (start_ok) begin
      op_q    <= op;
      shamt_q <= shamt;
    end
  end

  // FSM state register.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state; abort wins over everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_RUN;
      end
      S_RUN: begin
        if (abort)               state_d = S_IDLE;
        else if (load && c_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)         state_d = S_IDLE;
        else if (acc_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: busy and one-hot function select.
  always_comb begin
    busy      = (state_q != S_IDLE);
    sha3_f_xy = 1'b0;
    sha3_f_x1 = 1'b0;
    sha3_f_x2 = 1'b0;
    sha3_f_x4 = 1'b0;
    sha3_f_yx = 1'b0;
    if (busy) begin
      unique case (1'b1)
        op_q == 3'(OP_XY): sha3_f_xy = 1'b1;
        op_q == 3'(OP_X1): sha3_f_x1 = 1'b1;
        op_q == 3'(OP_X2): sha3_f_x2 = 1'b1;
        op_q == 3'(OP_X4): sha3_f_x4 = 1'b1;
        op_q == 3'(OP_YX): sha3_f_yx = 1'b1;
        default: ;
      endcase
    end
  end

  // Beat register: load, hold under stall, clear on accept.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_last  <= 1'b0;
    end else if (kill) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_addr  <= addr_d;
      out_x     <= x;
      out_y     <= y;
      out_last  <= c_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Status pulses for completion and rejected start.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= (state_q == S_DRAIN) && !abort && acc_last;
      err  <= start_bad;
    end
  end

endmodule

// File: tb/tb_xc_sha3_lane_seq.sv
// Randomized bench for xc_sha3_lane_seq with a lane-index model.
// Covers ops, backpressure, abort, illegal op, async reset.
module tb_xc_sha3_lane_seq;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [1:0]  shamt = '0;
  logic [31:0] base = '0;
  logic        abort = 1'b0;
  logic        busy, done, err;
  logic [31:0] sha3_rs1, sha3_rs2;
  logic [1:0]  sha3_shamt;
  logic        f_xy, f_x1, f_x2, f_x4, f_yx;
  logic [31:0] sha3_result;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_addr;
  logic [2:0]  out_x, out_y;
  logic        out_last;

  int cmp_n = 0;
  int bad_n = 0;

  always #5 g_clk = ~g_clk;

  xc_sha3_lane_seq dut (
    .g_clk       (g_clk),
    .g_reset     (g_reset),
    .start       (start),
    .op          (op),
    .shamt       (shamt),
    .base        (base),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .sha3_rs1    (sha3_rs1),
    .sha3_rs2    (sha3_rs2),
    .sha3_shamt  (sha3_shamt),
    .sha3_f_xy   (f_xy),
    .sha3_f_x1   (f_x1),
    .sha3_f_x2   (f_x2),
    .sha3_f_x4   (f_x4),
    .sha3_f_yx   (f_yx),
    .sha3_result (sha3_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_last    (out_last)
  );

  // Keccak lane index for each function, then post-shift.
  function automatic logic [31:0] lane_idx(
    input int o, input int x, input int y, input int sh
  );
    int i;
    case (o)
      0:       i = x + 5 * y;
      1:       i = ((x + 1) % 5) + 5 * y;
      2:       i = ((x + 2) % 5) + 5 * y;
      3:       i = ((x + 4) % 5) + 5 * y;
      default: i = y + 5 * ((2 * x + 3 * y) % 5);
    endcase
    return 32'(i << sh);
  endfunction

  // Index unit stand-in, selected by the one-hot function lines.
  logic [4:0] fsel;
  assign fsel = {f_yx, f_x4, f_x2, f_x1, f_xy};
  always_comb begin
    sha3_result = 32'hdead_beef;
    case (fsel)
      5'b00001: sha3_result = lane_idx(0, int'(sha3_rs1), int'(sha3_rs2), int'(sha3_shamt));
      5'b00010: sha3_result = lane_idx(1, int'(sha3_rs1), int'(sha3_rs2), int'(sha3_shamt));
      5'b00100: sha3_result = lane_idx(2, int'(sha3_rs1), int'(sha3_rs2), int'(sha3_shamt));
      5'b01000: sha3_result = lane_idx(3, int'(sha3_rs1), int'(sha3_rs2), int'(sha3_shamt));
      5'b10000: sha3_result = lane_idx(4, int'(sha3_rs1), int'(sha3_rs2), int'(sha3_shamt));
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    cmp_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(
    input int o, input int k, input int sh, input logic [31:0] b
  );
    logic [31:0] a;
    a = lane_idx(o, k % 5, k / 5, sh);
`ifdef XC_SHA3_LANE_SEQ_BASE_EN
    a = a + b;
`else
    a = a + 32'(0 * b);
`endif
    return a;
  endfunction

  // mode 0: ready high, 1: 4-cycle stall at beat 7, 2: random ready.
  task automatic run_seq(
    input int o, input int sh, input logic [31:0] b,
    input int mode, input int abort_at
  );
    int k, j, done_n, done_j, first_v, stall_left;
    logic errseen;
    logic [63:0] expv;
    k = 0; j = 0; done_n = 0; done_j = -1;
    first_v = -1; stall_left = 4; errseen = 1'b0;
    @(negedge g_clk);
    start = 1'b1; op = 3'(o); shamt = 2'(sh);
    base = b; out_ready = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    start = 1'b0; op = 3'($urandom); base = $urandom;
    shamt = 2'($urandom);
    chk("busy_on", 64'(busy), 64'(1));
    chk("fsel", 64'(fsel), 64'(5'b1 << o));
    chk("shamt_q", 64'(sha3_shamt), 64'(sh));
    chk("valid_c0", 64'(out_valid), 64'(0));
    while (j < 600) begin
      case (mode)
        0: out_ready = 1'b1;
        1: begin
          if (k == 7 && out_valid && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else out_ready = 1'b1;
        end
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (j == 5) begin start = 1'b1; op = 3'd7; end
      else start = 1'b0;
      if (err) errseen = 1'b1;
      if (done) begin done_n++; done_j = j; end
      if (out_valid && first_v < 0) first_v = j;
      if (out_valid) begin
        if (k < 25) begin
          expv = {25'b0, exp_addr(o, k, sh, b), 3'(k % 5), 3'(k / 5), k == 24};
          chk($sformatf("beat%0d", k), {25'b0, out_addr, out_x, out_y, out_last}, expv);
        end else begin
          chk("extra_beat", 64'(k), 64'(24));
        end
      end
      if (abort_at >= 0 && k == abort_at && out_valid) begin
        abort = 1'b1; start = 1'b1; op = 3'd0;
        @(negedge g_clk);
        abort = 1'b0; start = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_valid", 64'(out_valid), 64'(0));
        for (int i = 0; i < 4; i++) begin
          if (done || err || busy) done_n++;
          @(negedge g_clk);
        end
        chk("abort_quiet", 64'(done_n), 64'(0));
        return;
      end
      if (out_valid && out_ready) k++;
      if (done_j >= 0 && j == done_j + 2) break;
      @(negedge g_clk);
      j++;
    end
    start = 1'b0;
    chk("beats", 64'(k), 64'(25));
    chk("done_n", 64'(done_n), 64'(1));
    chk("no_err_busy", 64'(errseen), 64'(0));
    chk("idle_end", 64'(busy), 64'(0));
    if (mode == 0) begin
      chk("first_valid", 64'(first_v), 64'(1));
      chk("done_cycle", 64'(done_j), 64'(26));
    end
  endtask

  initial begin
    int o;
    #12;
    chk("rst_outs", {37'b0, busy, done, err, fsel, out_valid, out_addr[15:0], out_x, out_y, out_last, sha3_shamt},
        64'(0));
    chk("rst_rs", {sha3_rs1, sha3_rs2}, 64'(0));
    @(negedge g_clk);
    g_reset = 1'b0;

    run_seq(0, 0, 32'h0, 0, -1);
    run_seq(0, 3, 32'h0, 0, -1);
    run_seq(1, 0, 32'h0, 0, -1);
    run_seq(4, 0, 32'h0, 0, -1);
    run_seq(2, 1, 32'h0, 1, -1);
    run_seq(3, 2, 32'h40, 1, -1);
    run_seq(0, 3, 32'h1000, 0, -1);
    run_seq(0, 0, 32'h0, 0, 12);
    run_seq(0, 0, 32'h0, 0, -1);

    for (int n = 0; n < 6; n++) begin
      o = $urandom_range(0, 4);
      run_seq(o, $urandom_range(0, 3), $urandom, 2, -1);
    end
    run_seq(4, 3, 32'hffff_fff8, 2, -1);

    for (int n = 5; n < 8; n++) begin
      @(negedge g_clk);
      start = 1'b1; op = 3'(n);
      @(negedge g_clk);
      start = 1'b0;
      chk($sformatf("err_op%0d", n), {62'b0, err, busy}, 64'b10);
      @(negedge g_clk);
      chk("err_pulse", 64'(err), 64'(0));
    end

    @(negedge g_clk);
    start = 1'b1; op = 3'd1; out_ready = 1'b1;
    repeat (6) @(negedge g_clk);
    start = 1'b0;
    #2 g_reset = 1'b1;
    #1;
    chk("async_rst", {46'b0, busy, out_valid, out_addr[7:0], out_x, out_y, fsel[1:0]}, 64'(0));
    @(negedge g_clk);
    g_reset = 1'b0;
    run_seq(0, 0, 32'h0, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end

endmodule
